// File: rtl/uart_receive_datapath.sv
// UART receive data path: frame shift register, bit counter, parity/stop
// evaluation and a show-ahead RX FIFO of {bi, fe, pe, data[7:0]} entries.
module uart_receive_datapath #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        pclk,
  input  logic        preset,
  input  logic        rx_data,
  input  logic        receive_shift_en,
  input  logic        receive_frame_counter_en,
  input  logic        receive_frame_counter_clear,
  input  logic        error_check,
  input  logic        uart_break,
  input  logic        receive_load_en,
  input  logic [1:0]  wls,
  input  logic        pen,
  input  logic        eps,
  input  logic        fifo_rst,
  input  logic        rx_fifo_rd_en,
  input  logic        ovr_clr,
  output logic        receive_done,
  output logic        all_zero,
  output logic [10:0] rx_fifo_rdata,
  output logic        rx_fifo_empty,
  output logic        rx_fifo_full,
  output logic [6:0]  rx_fifo_level,
  output logic        rx_overrun
);

  localparam int ENTRY_W = 11;
  localparam int AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [3:0]         bit_cnt_q, bit_cnt_d;
  logic [9:0]         shreg_q, shreg_d;
  logic [1:0]         wls_q, wls_d;
  logic               pen_q, pen_d;
  logic               eps_q, eps_d;
  logic [9:0]         hold_q, hold_d;
  logic               break_q, break_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [6:0]         level_q, level_d;
  logic               ovr_q, ovr_d;
  logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];

  logic [3:0]         word_len_s;
  logic [3:0]         frame_len_s;
  logic [9:0]         frame_mask_s;
  logic [7:0]         word_mask_s;
  logic [7:0]         data_s;
  logic               pe_s;
  logic               fe_s;
  logic               full_s;
  logic               empty_s;
  logic               push_s;
  logic               pop_s;
  logic               ovr_set_s;
  logic [ENTRY_W-1:0] entry_s;

  // Frame geometry always follows the configuration latched at the first bit
  always_comb begin
    word_len_s   = {2'b00, wls_q} + 4'd5;
    frame_len_s  = word_len_s + {3'b000, pen_q} + 4'd1;
    frame_mask_s = ~(10'h3FF << frame_len_s);
    word_mask_s  = ~(8'hFF << word_len_s);
    data_s       = shreg_q[7:0] & word_mask_s;
    pe_s         = pen_q & (^data_s ^ shreg_q[word_len_s] ^ ~eps_q);
    fe_s         = ~shreg_q[frame_len_s - 4'd1];
  end

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    wls_d     = wls_q;
    pen_d     = pen_q;
    eps_d     = eps_q;
    hold_d    = hold_q;

    if (receive_frame_counter_clear) begin
      bit_cnt_d = 4'd0;
    end else if (receive_frame_counter_en && (bit_cnt_q < frame_len_s)) begin
      bit_cnt_d = bit_cnt_q + 4'd1;
    end else begin
      bit_cnt_d = bit_cnt_q;
    end

    // First bit of a frame starts a clean register and freezes the format
    if (receive_shift_en) begin
      if (bit_cnt_q == 4'd0) begin
        shreg_d = {9'b0_0000_0000, rx_data};
        wls_d   = wls;
        pen_d   = pen;
        eps_d   = eps;
      end else if (bit_cnt_q < 4'd10) begin
        shreg_d[bit_cnt_q] = rx_data;
      end else begin
        shreg_d = shreg_q;
      end
    end else begin
      shreg_d = shreg_q;
    end

    if (error_check) begin
      hold_d = {fe_s, pe_s, data_s};
    end else begin
      hold_d = hold_q;
    end
  end

  always_comb begin
    full_s    = (level_q == 7'(FIFO_DEPTH));
    empty_s   = (level_q == 7'd0);
    push_s    = receive_load_en & ~fifo_rst & (~full_s | rx_fifo_rd_en);
    pop_s     = rx_fifo_rd_en & ~empty_s & ~fifo_rst;
    ovr_set_s = receive_load_en & full_s & ~rx_fifo_rd_en & ~fifo_rst;
    entry_s   = {break_q, hold_q};
    break_d   = uart_break | (break_q & ~push_s);
    ovr_d     = ovr_set_s | (ovr_q & ~ovr_clr);

    if (fifo_rst) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = 7'd0;
    end else begin
      wr_ptr_d = push_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop_s  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      level_d  = level_q + {6'd0, push_s} - {6'd0, pop_s};
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      bit_cnt_q <= 4'd0;
      shreg_q   <= 10'd0;
      wls_q     <= 2'b00;
      pen_q     <= 1'b0;
      eps_q     <= 1'b0;
      hold_q    <= 10'd0;
      break_q   <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= 7'd0;
      ovr_q     <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      wls_q     <= wls_d;
      pen_q     <= pen_d;
      eps_q     <= eps_d;
      hold_q    <= hold_d;
      break_q   <= break_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      ovr_q     <= ovr_d;
    end
  end

  // Storage needs no reset: the read port is forced to zero while empty
  always_ff @(posedge pclk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= entry_s;
    end
  end

  assign receive_done  = (bit_cnt_q == frame_len_s);
  assign all_zero      = ~|(shreg_q & frame_mask_s);
  assign rx_fifo_rdata = empty_s ? {ENTRY_W{1'b0}} : mem_q[rd_ptr_q];
  assign rx_fifo_empty = empty_s;
  assign rx_fifo_full  = full_s;
  assign rx_fifo_level = level_q;
  assign rx_overrun    = ovr_q;

endmodule
